// File: rtl/butterfly_add_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : butterfly_add_seq_if
// Description : Operand / result handshake bundle for butterfly_add_seq.
//               Operand side : i_valid, o_ready, i_A, i_B
//               Result side  : o_valid, i_ready, o_sum, o_diff
//               Status       : o_busy, o_count
//               Signal names are written from the sequencer's point of view.
//               The slave modport is the sequencer. The master modport is
//               the surrounding datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface butterfly_add_seq_if #(
    parameter int COMP_W = 8
);
    logic                  i_valid;
    logic                  o_ready;
    logic [2*COMP_W-1:0]   i_A;
    logic [2*COMP_W-1:0]   i_B;
    logic                  o_valid;
    logic                  i_ready;
    logic [2*COMP_W-1:0]   o_sum;
    logic [2*COMP_W-1:0]   o_diff;
    logic                  o_busy;
    logic [7:0]            o_count;

    modport slave (
        input  i_valid, i_A, i_B, i_ready,
        output o_ready, o_valid, o_sum, o_diff, o_busy, o_count
    );

    modport master (
        output i_valid, i_A, i_B, i_ready,
        input  o_ready, o_valid, o_sum, o_diff, o_busy, o_count
    );
endinterface
`default_nettype wire

// File: rtl/butterfly_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : complex_add
// Description : Packed complex adder {real, imag}. Each component is added
//               modulo 2^COMP_W, with no carry between the two components.
//               i_a, i_b : packed operands
//               o_y      : packed sum
// Revision    : 1.0 - initial release
// ============================================================================
module complex_add #(
    parameter int COMP_W = 8
) (
    input  wire logic [2*COMP_W-1:0] i_a,
    input  wire logic [2*COMP_W-1:0] i_b,
    output logic      [2*COMP_W-1:0] o_y
);
    logic [COMP_W-1:0] w_re;
    logic [COMP_W-1:0] w_im;

    assign w_re = i_a[2*COMP_W-1:COMP_W] + i_b[2*COMP_W-1:COMP_W];
    assign w_im = i_a[COMP_W-1:0]        + i_b[COMP_W-1:0];
    assign o_y  = {w_re, w_im};
endmodule

// ============================================================================
// Module      : butterfly_add_seq
// Description : Radix-2 butterfly sequencer. It time-shares one complex_add
//               to produce A+B (SUM cycle) and then A-B (DIFF cycle, which
//               feeds the adder a negated B). Both results are held until
//               the downstream stage accepts them.
//               i_clk   : clock, rising edge
//               i_rst_n : synchronous active-low reset
//               bus     : handshake bundle (slave modport)
// Revision    : 1.0 - initial release
// ============================================================================
module butterfly_add_seq #(
    parameter int COMP_W = 8
) (
    input  wire logic         i_clk,
    input  wire logic         i_rst_n,
    butterfly_add_seq_if.slave bus
);
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_sum  = 2'd1;
    localparam logic [1:0] c_st_diff = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    logic [1:0]          r_state;
    logic [2*COMP_W-1:0] r_a;
    logic [2*COMP_W-1:0] r_b;
    logic [2*COMP_W-1:0] r_sum;
    logic [2*COMP_W-1:0] r_diff;
    logic [7:0]          r_count;

    logic [2*COMP_W-1:0] w_neg_b;
    logic [2*COMP_W-1:0] w_add_b;
    logic [2*COMP_W-1:0] w_add_y;

    // Negate each component independently. The most negative value maps to
    // itself, so A - (-max) wraps exactly as the adder does.
    assign w_neg_b = {-r_b[2*COMP_W-1:COMP_W], -r_b[COMP_W-1:0]};
    assign w_add_b = (r_state == c_st_diff) ? w_neg_b : r_b;

    complex_add #(
        .COMP_W (COMP_W)
    ) u_add (
        .i_a (r_a),
        .i_b (w_add_b),
        .o_y (w_add_y)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= c_st_idle;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_diff  <= '0;
            r_count <= 8'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.i_valid) begin
                        r_a     <= bus.i_A;
                        r_b     <= bus.i_B;
                        r_state <= c_st_sum;
                    end
                end
                c_st_sum: begin
                    r_sum   <= w_add_y;
                    r_state <= c_st_diff;
                end
                c_st_diff: begin
                    r_diff  <= w_add_y;
                    r_state <= c_st_done;
                end
                c_st_done: begin
                    if (bus.i_ready) begin
                        r_count <= r_count + 8'd1;
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Handshake and status outputs decode directly from the state register,
    // so i_valid and i_ready have no combinational path to them.
    assign bus.o_ready = (r_state == c_st_idle);
    assign bus.o_valid = (r_state == c_st_done);
    assign bus.o_busy  = (r_state != c_st_idle);
    assign bus.o_sum   = r_sum;
    assign bus.o_diff  = r_diff;
    assign bus.o_count = r_count;
endmodule
`default_nettype wire

// File: tb/tb_butterfly_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_butterfly_add_seq
// Description : Directed self-checking bench for butterfly_add_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_butterfly_add_seq;
    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_pass;

    butterfly_add_seq_if #(.COMP_W(8)) bus ();

    butterfly_add_seq #(
        .COMP_W (8)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (!bus.o_ready && w < 10) begin
            step();
            w++;
        end
        if (!bus.o_ready) check("idle_timeout", 32'd0, 32'd1);
    endtask

    // Present one pair with i_ready held high and check every stage.
    task automatic run_pair(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] s, input logic [15:0] d, input logic [7:0] cnt);
        wait_idle();
        bus.i_ready = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_A     = a;
        bus.i_B     = b;
        step();                                   // handshake edge t
        bus.i_valid = 1'b0;
        bus.i_A     = 16'hDEAD;
        bus.i_B     = 16'hBEEF;
        check({tag, "_busy_t"},   {31'd0, bus.o_busy},  32'd1);
        check({tag, "_ready_t"},  {31'd0, bus.o_ready}, 32'd0);
        check({tag, "_valid_t"},  {31'd0, bus.o_valid}, 32'd0);
        step();                                   // t+1
        check({tag, "_sum_t1"},   {16'd0, bus.o_sum},   {16'd0, s});
        check({tag, "_valid_t1"}, {31'd0, bus.o_valid}, 32'd0);
        step();                                   // t+2
        check({tag, "_valid_t2"}, {31'd0, bus.o_valid}, 32'd1);
        check({tag, "_sum"},      {16'd0, bus.o_sum},   {16'd0, s});
        check({tag, "_diff"},     {16'd0, bus.o_diff},  {16'd0, d});
        step();                                   // accept edge
        check({tag, "_valid_acc"}, {31'd0, bus.o_valid}, 32'd0);
        check({tag, "_ready_acc"}, {31'd0, bus.o_ready}, 32'd1);
        check({tag, "_count"},     {24'd0, bus.o_count}, {24'd0, cnt});
    endtask

    initial begin
        int bad;
        int prev;
        int w;
        n_checks    = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_A     = 16'h0;
        bus.i_B     = 16'h0;
        step();
        step();
        check("rst_ready", {31'd0, bus.o_ready}, 32'd1);
        check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
        check("rst_busy",  {31'd0, bus.o_busy},  32'd0);
        check("rst_sum",   {16'd0, bus.o_sum},   32'd0);
        check("rst_diff",  {16'd0, bus.o_diff},  32'd0);
        check("rst_count", {24'd0, bus.o_count}, 32'd0);
        rst_n = 1'b1;
        step();

        run_pair("basic", 16'h0AEF, 16'h0D16, 16'h1705, 16'hFDD9, 8'd1);
        run_pair("wrap1", 16'h7F80, 16'h0101, 16'h8081, 16'h7E7F, 8'd2);
        run_pair("wrap2", 16'h0000, 16'h8000, 16'h8000, 16'h8000, 8'd3);
        run_pair("pint",  16'h0043, 16'h01A4, 16'h01E7, 16'hFF9F, 8'd4);

        // Backpressure: hold i_ready low in DONE and disturb the inputs.
        wait_idle();
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_A     = 16'h0AEF;
        bus.i_B     = 16'h0D16;
        step();
        step();
        step();                                   // now in DONE
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            bus.i_valid = i[0];
            bus.i_A     = 16'h1111 * i[15:0];
            bus.i_B     = 16'h2222;
            step();
            if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0 ||
                bus.o_sum !== 16'h1705 || bus.o_diff !== 16'hFDD9 ||
                bus.o_count !== 8'd4) bad++;
        end
        check("bp_hold_errors", bad, 32'd0);
        check("bp_sum",   {16'd0, bus.o_sum},   32'h1705);
        check("bp_count", {24'd0, bus.o_count}, 32'd4);
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        step();
        check("bp_ready_after", {31'd0, bus.o_ready}, 32'd1);
        check("bp_valid_after", {31'd0, bus.o_valid}, 32'd0);
        check("bp_count_after", {24'd0, bus.o_count}, 32'd5);

        // Reset while in DIFF.
        bus.i_valid = 1'b1;
        bus.i_A     = 16'h7F80;
        bus.i_B     = 16'h0101;
        step();                                   // handshake
        bus.i_valid = 1'b0;
        step();                                   // now in DIFF
        rst_n = 1'b0;
        step();
        check("mrst_sum",   {16'd0, bus.o_sum},   32'd0);
        check("mrst_diff",  {16'd0, bus.o_diff},  32'd0);
        check("mrst_valid", {31'd0, bus.o_valid}, 32'd0);
        check("mrst_busy",  {31'd0, bus.o_busy},  32'd0);
        check("mrst_ready", {31'd0, bus.o_ready}, 32'd1);
        check("mrst_count", {24'd0, bus.o_count}, 32'd0);
        rst_n = 1'b1;
        run_pair("postrst", 16'h0043, 16'h01A4, 16'h01E7, 16'hFF9F, 8'd1);

        // Back-to-back: 256 pairs from a fresh reset, count wraps to 0.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        bus.i_A     = 16'h0AEF;
        bus.i_B     = 16'h0D16;
        bad  = 0;
        prev = 0;
        for (int i = 0; i < 256; i++) begin
            w = 0;
            while (!bus.o_ready && w < 8) begin
                step();
                w++;
            end
            if (!bus.o_ready) bad++;
            if (i > 0 && (cyc - prev) != 4) bad++;
            prev = cyc;
            step();
        end
        bus.i_valid = 1'b0;
        w = 0;
        while (!bus.o_ready && w < 8) begin
            step();
            w++;
        end
        check("b2b_spacing_errors", bad, 32'd0);
        check("b2b_count_wrap", {24'd0, bus.o_count}, 32'd0);
        check("b2b_sum",  {16'd0, bus.o_sum},  32'h1705);
        check("b2b_diff", {16'd0, bus.o_diff}, 32'hFDD9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
